// File: rtl/jtag_host_if.sv
// rtl/jtag_host_if.sv - command/response handshake bundle between a requester and jtag_host
interface jtag_host_if #(
    parameter int DR_MAX = 32
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_op;
    logic [5:0]        cmd_len;
    logic [DR_MAX-1:0] cmd_data;
    logic              rsp_valid;
    logic [DR_MAX-1:0] rsp_data;
    logic              busy;

    modport master (
        output cmd_valid, cmd_op, cmd_len, cmd_data,
        input  cmd_ready, rsp_valid, rsp_data, busy
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_len, cmd_data,
        output cmd_ready, rsp_valid, rsp_data, busy
    );
endinterface

// File: rtl/jtag_host.sv
// rtl/jtag_host.sv - JTAG initiator driving tck/tms/tdi and sampling tdo; optional TAP reset pin via JTAG_HOST_TRST_EN
module jtag_host #(
    parameter int CLK_DIV = 2,
    parameter int IR_LEN  = 4,
    parameter int DR_MAX  = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    jtag_host_if.slave  bus,
    output logic        tck,
    output logic        tms,
    output logic        tdi,
    input  logic        tdo
`ifdef JTAG_HOST_TRST_EN
    ,
    output logic        trst_n_out
`endif
);

    localparam logic [1:0] OP_RESET = 2'd0;
    localparam logic [1:0] OP_IR    = 2'd1;
    localparam logic [1:0] OP_DR    = 2'd2;
    localparam logic [1:0] OP_IDLE  = 2'd3;

    localparam int              DW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0]   DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [6:0]      DR_CAP   = (DR_MAX > 63) ? 7'd63 : 7'(DR_MAX);

    typedef enum logic [2:0] {IDLE, RST_SEQ, HDR, SHIFT, TRL, RUN, DONE} state_t;

    state_t             r_state;
    logic [5:0]         r_cnt;
    logic [DW-1:0]      r_div;
    logic [1:0]         r_op;
    logic [5:0]         r_len;
    logic [DR_MAX-1:0]  r_data;
    logic [DR_MAX-1:0]  r_rx;
    logic               r_synced;
    logic               r_ready;
    logic               r_rsp_valid;
    logic [DR_MAX-1:0]  r_rsp_data;
    logic               r_tck;
    logic               r_tms;
    logic               r_tdi;
`ifdef JTAG_HOST_TRST_EN
    logic               r_trst;
`endif

    logic               w_accept;
    logic               w_run;
    logic               w_step;
    logic [5:0]         w_cmd_n;
    state_t             w_tgt_state;
    logic [5:0]         w_tgt_cnt;
    logic               w_tgt_done;
    logic               w_tgt_tms;
    logic               w_sync_set;
    logic [31:0]        w_shamt;
    logic [DR_MAX-1:0]  w_rsp_align;

    assign w_accept = r_ready && bus.cmd_valid;
    assign w_run    = (r_state == RST_SEQ) || (r_state == HDR) || (r_state == SHIFT) ||
                      (r_state == TRL) || (r_state == RUN);
    // A step is the last clk of a high phase: tdo is sampled and the next tck is set up.
    assign w_step   = w_run && r_tck && (r_div == DIV_LAST);

    // Bits were shifted in from the top, so move the n captured bits down to bit 0.
    assign w_shamt     = 32'(DR_MAX) - 32'(r_len);
    assign w_rsp_align = r_rx >> w_shamt;

    always_comb begin
        w_cmd_n = bus.cmd_len;
        case (bus.cmd_op)
            OP_IR: w_cmd_n = 6'(IR_LEN);
            OP_DR: begin
                if (bus.cmd_len == 6'd0)
                    w_cmd_n = 6'd1;
                else if ({1'b0, bus.cmd_len} > DR_CAP)
                    w_cmd_n = DR_CAP[5:0];
                else
                    w_cmd_n = bus.cmd_len;
            end
            default: w_cmd_n = bus.cmd_len;
        endcase
    end

    // Decide which tck comes next (state/count) or whether the command is complete.
    always_comb begin
        w_tgt_state = r_state;
        w_tgt_cnt   = '0;
        w_tgt_done  = 1'b0;
        w_sync_set  = 1'b0;
        w_tgt_tms   = 1'b0;
        if (w_accept) begin
            if (bus.cmd_op == OP_RESET || !r_synced)
                w_tgt_state = RST_SEQ;
            else if (bus.cmd_op == OP_IDLE) begin
                if (bus.cmd_len == 6'd0)
                    w_tgt_done = 1'b1;
                else
                    w_tgt_state = RUN;
            end else
                w_tgt_state = HDR;
        end else begin
            case (r_state)
                RST_SEQ: begin
                    if (r_cnt != 6'd5) begin
                        w_tgt_cnt = r_cnt + 6'd1;
                    end else begin
                        w_sync_set = 1'b1;
                        if (r_op == OP_RESET)
                            w_tgt_done = 1'b1;
                        else if (r_op == OP_IDLE) begin
                            if (r_len == 6'd0)
                                w_tgt_done = 1'b1;
                            else
                                w_tgt_state = RUN;
                        end else
                            w_tgt_state = HDR;
                    end
                end
                HDR: begin
                    if (r_cnt != ((r_op == OP_IR) ? 6'd3 : 6'd2))
                        w_tgt_cnt = r_cnt + 6'd1;
                    else
                        w_tgt_state = SHIFT;
                end
                SHIFT: begin
                    if (r_cnt != r_len - 6'd1)
                        w_tgt_cnt = r_cnt + 6'd1;
                    else
                        w_tgt_state = TRL;
                end
                TRL: begin
                    if (r_cnt == 6'd0)
                        w_tgt_cnt = 6'd1;
                    else
                        w_tgt_done = 1'b1;
                end
                RUN: begin
                    if (r_cnt != r_len - 6'd1)
                        w_tgt_cnt = r_cnt + 6'd1;
                    else
                        w_tgt_done = 1'b1;
                end
                default: w_tgt_state = r_state;
            endcase
        end
        case (w_tgt_state)
            RST_SEQ: w_tgt_tms = (w_tgt_cnt != 6'd5);
            HDR:     w_tgt_tms = (r_op == OP_IR) ? (w_tgt_cnt < 6'd2) : (w_tgt_cnt == 6'd0);
            SHIFT:   w_tgt_tms = (w_tgt_cnt == r_len - 6'd1);
            TRL:     w_tgt_tms = (w_tgt_cnt == 6'd0);
            default: w_tgt_tms = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_div       <= '0;
            r_op        <= OP_RESET;
            r_len       <= '0;
            r_data      <= '0;
            r_rx        <= '0;
            r_synced    <= 1'b0;
            r_ready     <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_tck       <= 1'b0;
            r_tms       <= 1'b1;
            r_tdi       <= 1'b0;
`ifdef JTAG_HOST_TRST_EN
            r_trst      <= 1'b1;
`endif
        end else begin
            r_rsp_valid <= 1'b0;
            if (w_accept) begin
                r_op    <= bus.cmd_op;
                r_len   <= w_cmd_n;
                r_data  <= bus.cmd_data;
                r_rx    <= '0;
                r_ready <= 1'b0;
            end
            if (w_step && r_state == SHIFT)
                r_rx <= {tdo, r_rx[DR_MAX-1:1]};
            if (w_accept || w_step) begin
                r_tck <= 1'b0;
                r_div <= '0;
                if (w_sync_set)
                    r_synced <= 1'b1;
                if (w_tgt_done) begin
                    r_state     <= DONE;
                    r_cnt       <= '0;
                    r_ready     <= 1'b1;
                    r_rsp_valid <= 1'b1;
                    r_rsp_data  <= w_accept ? '0 : w_rsp_align;
                    r_tdi       <= 1'b0;
`ifdef JTAG_HOST_TRST_EN
                    r_trst      <= 1'b1;
`endif
                end else begin
                    r_state <= w_tgt_state;
                    r_cnt   <= w_tgt_cnt;
                    r_tms   <= w_tgt_tms;
                    if (w_tgt_state == SHIFT) begin
                        r_tdi  <= r_data[0];
                        r_data <= r_data >> 1;
                    end else begin
                        r_tdi  <= 1'b0;
                    end
`ifdef JTAG_HOST_TRST_EN
                    r_trst  <= !(w_tgt_state == RST_SEQ && w_tgt_cnt == 6'd0);
`endif
                end
            end else if (w_run) begin
                if (r_div == DIV_LAST) begin
                    r_div <= '0;
                    r_tck <= 1'b1;
                end else begin
                    r_div <= r_div + 1'b1;
                end
            end else if (r_state == DONE) begin
                r_state <= IDLE;
            end
        end
    end

    assign bus.cmd_ready = r_ready;
    assign bus.busy      = ~r_ready;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_data  = r_rsp_data;
    assign tck           = r_tck;
    assign tms           = r_tms;
    assign tdi           = r_tdi;
`ifdef JTAG_HOST_TRST_EN
    assign trst_n_out    = r_trst;
`endif

endmodule

// File: tb/tb_jtag_host.sv
// tb/tb_jtag_host.sv - scoreboard bench for jtag_host against a behavioural TAP and command model
module tb_jtag_host;

    localparam int CLK_DIV = 2;
    localparam int IR_LEN  = 4;
    localparam logic [3:0]  IDC_IR = 4'b1110;
    localparam logic [31:0] IDCODE = 32'h000FAF01;

    typedef struct {
        int           tcks;
        int           lat;
        int           trst;
        logic [31:0]  rsp;
        logic [127:0] tms;
        logic [127:0] tdi;
    } exp_t;

    typedef enum logic [3:0] {T_TLR, T_RTI, T_SELDR, T_CAPDR, T_SHDR, T_EX1DR, T_PADR, T_EX2DR,
                              T_UPDR, T_SELIR, T_CAPIR, T_SHIR, T_EX1IR, T_PAIR, T_EX2IR, T_UPIR} tap_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic tck, tms, tdi, tdo;
`ifdef JTAG_HOST_TRST_EN
    logic trst_n_out;
`endif

    jtag_host_if #(.DR_MAX(32)) bus ();

    jtag_host #(.CLK_DIV(CLK_DIV), .IR_LEN(IR_LEN), .DR_MAX(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus.slave),
        .tck        (tck),
        .tms        (tms),
        .tdi        (tdi),
        .tdo        (tdo)
`ifdef JTAG_HOST_TRST_EN
        ,
        .trst_n_out (trst_n_out)
`endif
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    exp_t exp_q[$];
    logic m_synced = 1'b0;
    logic [3:0] m_ir = IDC_IR;

    // Behavioural TAP: tdo changes on posedge tck while shifting.
    tap_t ts = T_TLR;
    tap_t tn;
    logic [3:0]  t_ir = IDC_IR;
    logic [3:0]  t_irs = 4'b0;
    logic [31:0] t_dr = 32'b0;
    logic        t_tdo = 1'b0;
    assign tdo = t_tdo;

    initial begin
        forever begin
            @(posedge tck);
            case (ts)
                T_TLR:   tn = tms ? T_TLR   : T_RTI;
                T_RTI:   tn = tms ? T_SELDR : T_RTI;
                T_SELDR: tn = tms ? T_SELIR : T_CAPDR;
                T_CAPDR: tn = tms ? T_EX1DR : T_SHDR;
                T_SHDR:  tn = tms ? T_EX1DR : T_SHDR;
                T_EX1DR: tn = tms ? T_UPDR  : T_PADR;
                T_PADR:  tn = tms ? T_EX2DR : T_PADR;
                T_EX2DR: tn = tms ? T_UPDR  : T_SHDR;
                T_UPDR:  tn = tms ? T_SELDR : T_RTI;
                T_SELIR: tn = tms ? T_TLR   : T_CAPIR;
                T_CAPIR: tn = tms ? T_EX1IR : T_SHIR;
                T_SHIR:  tn = tms ? T_EX1IR : T_SHIR;
                T_EX1IR: tn = tms ? T_UPIR  : T_PAIR;
                T_PAIR:  tn = tms ? T_EX2IR : T_PAIR;
                T_EX2IR: tn = tms ? T_UPIR  : T_SHIR;
                default: tn = tms ? T_SELDR : T_RTI;
            endcase
            case (ts)
                T_TLR:   t_ir = IDC_IR;
                T_CAPDR: t_dr = (t_ir == IDC_IR) ? IDCODE : 32'h0;
                T_SHDR: begin
                    t_tdo = t_dr[0];
                    t_dr  = (t_ir == IDC_IR) ? {tdi, t_dr[31:1]} : {31'b0, tdi};
                end
                T_CAPIR: t_irs = 4'b0101;
                T_SHIR: begin
                    t_tdo = t_irs[0];
                    t_irs = {tdi, t_irs[3:1]};
                end
                T_UPIR:  t_ir = t_irs;
                default: ;
            endcase
            ts = tn;
        end
    end

`ifdef JTAG_HOST_TRST_EN
    initial begin
        forever begin
            @(negedge trst_n_out);
            ts   = T_TLR;
            t_ir = IDC_IR;
        end
    end
`endif

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: expected tck stream and response straight from the command rules.
    task automatic push_exp(input logic [1:0] op, input logic [5:0] len, input logic [31:0] data);
        exp_t e;
        int k;
        int n;
        int ln;
        logic [31:0] mask;
        e.tms = '0; e.tdi = '0; e.rsp = '0; e.trst = 0;
        k  = 0;
        ln = int'(len);
        if (op == 2'd0 || !m_synced) begin
            for (int i = 0; i < 6; i++) begin
                e.tms[k] = (i < 5);
                k++;
            end
            m_synced = 1'b1;
            m_ir     = IDC_IR;
            e.trst   = 2 * CLK_DIV;
        end
        if (op == 2'd1) begin
            e.tms[k] = 1'b1; e.tms[k+1] = 1'b1; k += 4;
            for (int i = 0; i < IR_LEN; i++) begin
                e.tdi[k] = data[i];
                e.tms[k] = (i == IR_LEN - 1);
                k++;
            end
            e.tms[k] = 1'b1; k += 2;
            e.rsp = 32'h5;
            m_ir  = data[3:0];
        end else if (op == 2'd2) begin
            n = (ln == 0) ? 1 : (ln > 32) ? 32 : ln;
            e.tms[k] = 1'b1; k += 3;
            for (int i = 0; i < n; i++) begin
                e.tdi[k] = data[i];
                e.tms[k] = (i == n - 1);
                k++;
            end
            e.tms[k] = 1'b1; k += 2;
            mask  = (n == 32) ? 32'hFFFF_FFFF : ((32'd1 << n) - 32'd1);
            e.rsp = ((m_ir == IDC_IR) ? IDCODE : {data[30:0], 1'b0}) & mask;
        end else if (op == 2'd3) begin
            k += ln;
        end
        e.tcks = k;
        e.lat  = 1 + 2 * CLK_DIV * k;
        exp_q.push_back(e);
    endtask

    // Monitor: logs the tck stream per command and scores every response.
    int cyc = 0, acc_cyc = 0, tck_cnt = 0, trst_cnt = 0, inv_err = 0;
    logic prev_tck = 1'b0;
    logic [127:0] tms_log = '0, tdi_log = '0;

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst_n) begin
                if ((bus.busy == bus.cmd_ready) || (bus.cmd_ready && tck && !bus.rsp_valid))
                    inv_err++;
                if (tck && !prev_tck) begin
                    if (tck_cnt < 128) begin
                        tms_log[tck_cnt] = tms;
                        tdi_log[tck_cnt] = tdi;
                    end
                    tck_cnt++;
                end
`ifdef JTAG_HOST_TRST_EN
                if (!trst_n_out) trst_cnt++;
`endif
                if (bus.rsp_valid) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_rsp", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("rsp_data", bus.rsp_data, e.rsp);
                        chk("tck_count", tck_cnt, e.tcks);
                        chk("latency", cyc - acc_cyc, e.lat);
                        chk("tms_seq", tms_log, e.tms);
                        chk("tdi_seq", tdi_log, e.tdi);
                        chk("tap_in_rti", ts, T_RTI);
`ifdef JTAG_HOST_TRST_EN
                        chk("trst_low_clks", trst_cnt, e.trst);
`endif
                    end
                end
                if (bus.cmd_valid && bus.cmd_ready) begin
                    acc_cyc  = cyc;
                    tck_cnt  = 0;
                    trst_cnt = 0;
                    tms_log  = '0;
                    tdi_log  = '0;
                end
            end
            prev_tck = tck;
        end
    end

    task automatic issue(input logic [1:0] op, input logic [5:0] len, input logic [31:0] data);
        int g;
        g = 0;
        @(posedge clk); #1;
        while (!bus.cmd_ready && g < 3000) begin
            @(posedge clk); #1;
            g++;
        end
        if (!bus.cmd_ready) begin
            chk("issue_timeout", 0, 1);
        end else begin
            push_exp(op, len, data);
            bus.cmd_op    = op;
            bus.cmd_len   = len;
            bus.cmd_data  = data;
            bus.cmd_valid = 1'b1;
            @(posedge clk); #1;
            bus.cmd_valid = 1'b0;
        end
    endtask

    task automatic wait_idle();
        int g;
        g = 0;
        while ((exp_q.size() != 0 || !bus.cmd_ready) && g < 5000) begin
            @(negedge clk);
            g++;
        end
        chk("idle_timeout", exp_q.size(), 0);
    endtask

    initial begin
        #900000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [1:0]  op;
        logic [5:0]  len;
        logic [31:0] data;
        int g;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 2'd0;
        bus.cmd_len   = 6'd0;
        bus.cmd_data  = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tck", tck, 0);
        chk("rst_tms", tms, 1);
        chk("rst_tdi", tdi, 0);
        chk("rst_cmd_ready", bus.cmd_ready, 1);
        chk("rst_busy", bus.busy, 0);
        chk("rst_rsp_valid", bus.rsp_valid, 0);
        chk("rst_rsp_data", bus.rsp_data, 0);
`ifdef JTAG_HOST_TRST_EN
        chk("rst_trst", trst_n_out, 1);
`endif
        rst_n = 1'b1;

        issue(2'd0, 6'd0, 32'd0);
        wait_idle();
        issue(2'd1, 6'd0, 32'hE);
        wait_idle();
        chk("ir_is_idcode", t_ir, IDC_IR);
        issue(2'd2, 6'd32, 32'd0);
        issue(2'd2, 6'd0, 32'hFFFF_FFFF);
        issue(2'd2, 6'd40, 32'hA5A5_5A5A);
        issue(2'd3, 6'd0, 32'd0);
        issue(2'd3, 6'd5, 32'hFFFF_FFFF);
        issue(2'd1, 6'd0, 32'hF);
        issue(2'd2, 6'd8, 32'h0000_00C3);
        issue(2'd2, 6'd32, 32'h1234_5678);
        issue(2'd0, 6'd0, 32'd0);
        wait_idle();

        // Host reset in the middle of shift bit 10 of a DR scan.
        issue(2'd2, 6'd32, 32'hDEAD_BEEF);
        g = 0;
        while (tck_cnt < 14 && g < 2000) begin
            @(negedge clk);
            g++;
        end
        chk("reach_shift_bit10", (tck_cnt >= 14), 1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("midrst_tck", tck, 0);
        chk("midrst_tms", tms, 1);
        chk("midrst_ready", bus.cmd_ready, 1);
        chk("midrst_rsp_valid", bus.rsp_valid, 0);
        exp_q.delete();
        m_synced = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        issue(2'd2, 6'd32, 32'd0);
        wait_idle();

        for (int t = 0; t < 40; t++) begin
            op   = 2'($urandom_range(0, 3));
            len  = 6'($urandom_range(0, 45));
            data = $urandom;
            if (op == 2'd1) begin
                case ($urandom_range(0, 2))
                    0: data = 32'hE;
                    1: data = 32'hF;
                    default: ;
                endcase
            end
            if (op == 2'd3) len = 6'($urandom_range(0, 8));
            issue(op, len, data);
        end
        wait_idle();

        chk("invariants", inv_err, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
